logic_op_engine: RTL and testbench

LOGIC_OP_ENGINE -- requirements
Module: logic_op_engine

---
 rtl/logic_op_engine.sv | 145 ++++++++++++++
 tb/tb_logic_op_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_engine.sv
// ---------------------------------------------------------------------------
// logic_op_engine
//
// Evaluates a one-bit logical operation on two operands and queues each
// result, together with the op code that produced it, in a 2-entry output
// FIFO (skid buffer). Each consumed result is tallied in a saturating
// true or false counter.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready is registered)
//   op, val1, val2      op code (00 !val1, 01 !val2, 10 &&, 11 ||) and operands
//   out_valid,out_ready result handshake at the FIFO head
//   out_result, out_op  head result and the op code that produced it
//   clr_cnt             synchronous clear of both counters
//   true_cnt, false_cnt counts of consumed results equal to 1 / 0
// ---------------------------------------------------------------------------
module logic_op_engine #(
  parameter int W1    = 3,
  parameter int W2    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W1-1:0]    val1,
  input  logic [W2-1:0]    val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [1:0]       out_op,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] true_cnt,
  output logic [CNT_W-1:0] false_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             mem_res_q [2];
  logic             mem_res_d [2];
  logic [1:0]       mem_op_q  [2];
  logic [1:0]       mem_op_d  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] true_cnt_q, true_cnt_d;
  logic [CNT_W-1:0] false_cnt_q, false_cnt_d;

  logic push;
  logic pop;
  logic new_result;
  logic head_result;

  assign head_result = mem_res_q[rd_ptr_q];
  assign out_valid   = (count_q != 2'd0);
  assign out_result  = head_result;
  assign out_op      = mem_op_q[rd_ptr_q];
  assign in_ready    = in_ready_q;
  assign true_cnt    = true_cnt_q;
  assign false_cnt   = false_cnt_q;

  // in_ready_q is only ever 1 below full, so a push can never overflow.
  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  // An operand counts as true when any of its bits is set.
  always_comb begin
    new_result = 1'b0;
    case (op)
      2'b00:   new_result = ~(|val1);
      2'b01:   new_result = ~(|val2);
      2'b10:   new_result = (|val1) && (|val2);
      default: new_result = (|val1) || (|val2);
    endcase
  end

  // FIFO bookkeeping: pointers wrap modulo 2, occupancy tracks push-pop.
  // in_ready is registered from the next occupancy so it never depends
  // combinationally on out_ready.
  always_comb begin
    mem_res_d = mem_res_q;
    mem_op_d  = mem_op_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      mem_res_d[wr_ptr_q] = new_result;
      mem_op_d[wr_ptr_q]  = op;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != 2'd2);
  end

  // Saturating statistics; a clear wins over a simultaneous pop.
  always_comb begin
    true_cnt_d  = true_cnt_q;
    false_cnt_d = false_cnt_q;
    if (clr_cnt) begin
      true_cnt_d  = '0;
      false_cnt_d = '0;
    end else if (pop) begin
      if (head_result) begin
        if (true_cnt_q != CNT_MAX) true_cnt_d = true_cnt_q + 1'b1;
      end else begin
        if (false_cnt_q != CNT_MAX) false_cnt_d = false_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_res_q[0] <= 1'b0;
      mem_res_q[1] <= 1'b0;
      mem_op_q[0]  <= 2'b00;
      mem_op_q[1]  <= 2'b00;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      in_ready_q   <= 1'b0;
      true_cnt_q   <= '0;
      false_cnt_q  <= '0;
    end else begin
      mem_res_q    <= mem_res_d;
      mem_op_q     <= mem_op_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      true_cnt_q   <= true_cnt_d;
      false_cnt_q  <= false_cnt_d;
    end
  end

endmodule

// File: tb/tb_logic_op_engine.sv
// ---------------------------------------------------------------------------
// tb_logic_op_engine
//
// Drives the default-width engine through directed vectors, corner-case
// sequences and random traffic against a queue-based reference model, and a
// second CNT_W=2 instance for counter saturation and clear priority.
// ---------------------------------------------------------------------------
module tb_logic_op_engine;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [2:0] val1;
  logic [3:0] val2;
  logic       out_valid;
  logic       out_ready;
  logic       out_result;
  logic [1:0] out_op;
  logic       clr_cnt;
  logic [7:0] true_cnt;
  logic [7:0] false_cnt;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [1:0] s_op;
  logic [2:0] s_val1;
  logic [3:0] s_val2;
  logic       s_out_valid;
  logic       s_out_ready;
  logic       s_out_result;
  logic [1:0] s_out_op;
  logic       s_clr_cnt;
  logic [1:0] s_true_cnt;
  logic [1:0] s_false_cnt;

  int errors = 0;
  int checks = 0;

  logic_op_engine #(.W1(3), .W2(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .val1(val1), .val2(val2), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .clr_cnt(clr_cnt), .true_cnt(true_cnt), .false_cnt(false_cnt)
  );

  logic_op_engine #(.W1(3), .W2(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .op(s_op), .val1(s_val1), .val2(s_val2), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_result(s_out_result), .out_op(s_out_op),
    .clr_cnt(s_clr_cnt), .true_cnt(s_true_cnt), .false_cnt(s_false_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of {result, op} entries plus counters.
  typedef struct {
    logic       res;
    logic [1:0] op;
  } entry_t;

  entry_t m_q[$];
  logic   m_ready = 1'b0;
  int     m_true  = 0;
  int     m_false = 0;
  localparam int M_MAX = 255;

  typedef struct {
    logic [1:0] op;
    logic [2:0] val1;
    logic [3:0] val2;
    logic       exp_res;
  } vec_t;

  vec_t vecs[12];

  function automatic logic ref_result(input logic [1:0] o, input logic [2:0] a,
                                      input logic [3:0] b);
    bit ta, tb;
    ta = (a != 0);
    tb = (b != 0);
    case (o)
      2'b00:   return !ta;
      2'b01:   return !tb;
      2'b10:   return ta && tb;
      default: return ta || tb;
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_output();
    check("out_valid", int'(out_valid), int'(m_q.size() > 0));
    check("in_ready", int'(in_ready), int'(m_ready));
    check("true_cnt", int'(true_cnt), m_true);
    check("false_cnt", int'(false_cnt), m_false);
    if (m_q.size() > 0) begin
      check("out_result", int'(out_result), int'(m_q[0].res));
      check("out_op", int'(out_op), int'(m_q[0].op));
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge and
  // compares the DUT against it 1 time unit after the edge.
  task automatic apply_stimulus(input logic iv, input logic [1:0] o,
                                input logic [2:0] a, input logic [3:0] b,
                                input logic ordy, input logic clr);
    bit     do_push, do_pop;
    entry_t e;
    in_valid  = iv;
    op        = o;
    val1      = a;
    val2      = b;
    out_ready = ordy;
    clr_cnt   = clr;
    do_push   = iv && m_ready;
    do_pop    = (m_q.size() > 0) && ordy;
    @(posedge clk);
    if (clr) begin
      m_true  = 0;
      m_false = 0;
    end else if (do_pop) begin
      if (m_q[0].res) m_true  = (m_true  < M_MAX) ? m_true + 1  : m_true;
      else            m_false = (m_false < M_MAX) ? m_false + 1 : m_false;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      e.res = ref_result(o, a, b);
      e.op  = o;
      m_q.push_back(e);
    end
    m_ready = (m_q.size() < 2);
    #1;
    check_output();
  endtask

  task automatic idle(input logic ordy);
    apply_stimulus(1'b0, 2'b00, 3'b000, 4'b0000, ordy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_ready = 1'b0;
    m_true  = 0;
    m_false = 0;
    check("rst out_valid", int'(out_valid), 0);
    check("rst in_ready", int'(in_ready), 0);
    check("rst out_result", int'(out_result), 0);
    check("rst out_op", int'(out_op), 0);
    check("rst true_cnt", int'(true_cnt), 0);
    check("rst false_cnt", int'(false_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    check("in_ready after release", int'(in_ready), 1);
  endtask

  initial begin
    int base_true;
    rst_n = 1'b0; in_valid = 0; op = 0; val1 = 0; val2 = 0;
    out_ready = 0; clr_cnt = 0;
    s_in_valid = 0; s_op = 0; s_val1 = 0; s_val2 = 0;
    s_out_ready = 0; s_clr_cnt = 0;
    #2;
    do_reset();

    // Basic ops with out_ready high: results 0,1,0,1 one cycle after acceptance.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] o;
      logic       exp_bits [4];
      exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1};
      o = 2'(i);
      apply_stimulus(1'b1, o, 3'b111, 4'b0000, 1'b1, 1'b0);
      check("basic valid", int'(out_valid), 1);
      check("basic result", int'(out_result), int'(exp_bits[i]));
      check("basic op", int'(out_op), i);
    end
    idle(1'b1);
    check("basic true_cnt", int'(true_cnt), 2);
    check("basic false_cnt", int'(false_cnt), 2);
    idle(1'b0);

    // Table of vectors with hand-derived results, streamed at full rate.
    vecs[0]  = '{2'b00, 3'b000, 4'b0000, 1'b1};
    vecs[1]  = '{2'b01, 3'b000, 4'b0000, 1'b1};
    vecs[2]  = '{2'b10, 3'b000, 4'b0000, 1'b0};
    vecs[3]  = '{2'b11, 3'b000, 4'b0000, 1'b0};
    vecs[4]  = '{2'b00, 3'b010, 4'b1000, 1'b0};
    vecs[5]  = '{2'b01, 3'b010, 4'b1000, 1'b0};
    vecs[6]  = '{2'b10, 3'b010, 4'b1000, 1'b1};
    vecs[7]  = '{2'b11, 3'b010, 4'b1000, 1'b1};
    vecs[8]  = '{2'b10, 3'b100, 4'b0000, 1'b0};
    vecs[9]  = '{2'b10, 3'b000, 4'b0001, 1'b0};
    vecs[10] = '{2'b11, 3'b000, 4'b0100, 1'b1};
    vecs[11] = '{2'b01, 3'b111, 4'b1111, 1'b0};
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, vecs[i].op, vecs[i].val1, vecs[i].val2, 1'b1, 1'b0);
      check("vec result", int'(out_result), int'(vecs[i].exp_res));
      check("vec op", int'(out_op), int'(vecs[i].op));
    end
    idle(1'b1);
    apply_stimulus(1'b0, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b1);
    check("clr true_cnt", int'(true_cnt), 0);

    // Backpressure: three requests, two accepted, third held until drain.
    apply_stimulus(1'b1, 2'b11, 3'b001, 4'b0000, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b11, 3'b001, 4'b0000, 1'b0, 1'b0);
    check("bp in_ready full", int'(in_ready), 0);
    apply_stimulus(1'b1, 2'b11, 3'b001, 4'b0000, 1'b0, 1'b0);
    check("bp held in_ready", int'(in_ready), 0);
    check("bp held result", int'(out_result), 1);
    apply_stimulus(1'b1, 2'b11, 3'b001, 4'b0000, 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b11, 3'b001, 4'b0000, 1'b1, 1'b0);
    apply_stimulus(1'b0, 2'b00, 3'b000, 4'b0000, 1'b1, 1'b0);
    apply_stimulus(1'b0, 2'b00, 3'b000, 4'b0000, 1'b1, 1'b0);
    check("bp true_cnt", int'(true_cnt), 3);
    check("bp drained", int'(out_valid), 0);

    // Push and pop together at occupancy 1: head moves to the new entry.
    apply_stimulus(1'b1, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b10, 3'b001, 4'b0000, 1'b1, 1'b0);
    check("pp in_ready", int'(in_ready), 1);
    check("pp head result", int'(out_result), 0);
    check("pp head op", int'(out_op), 2);
    idle(1'b0);
    idle(1'b1);
    check("pp empty", int'(out_valid), 0);

    // Random traffic against the model, with occasional clears.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 2'($urandom),
                     3'($urandom_range(0, 1) != 0 ? $urandom : 0),
                     4'($urandom_range(0, 1) != 0 ? $urandom : 0),
                     1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 40) == 0));
    end

    // Mid-stream reset with two entries buffered.
    idle(1'b1);
    idle(1'b1);
    base_true = int'(true_cnt);
    apply_stimulus(1'b1, 2'b11, 3'b001, 4'b0000, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b11, 3'b001, 4'b0000, 1'b0, 1'b0);
    check("pre-reset full", int'(in_ready), 0);
    check("pre-reset count", int'(true_cnt), base_true);
    #2;
    do_reset();
    idle(1'b1);
    check("no stale result", int'(out_valid), 0);

    // Saturation on the CNT_W=2 instance: five true pops, then clear + pop.
    s_op = 2'b01; s_val1 = 3'b000; s_val2 = 4'b0000; s_out_ready = 1'b1;
    s_in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sat true_cnt", int'(s_true_cnt), 3);
    check("sat false_cnt", int'(s_false_cnt), 0);
    check("sat drained", int'(s_out_valid), 0);
    s_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    check("sat pending", int'(s_out_valid), 1);
    s_clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    s_clr_cnt = 1'b0;
    check("clr pri true_cnt", int'(s_true_cnt), 0);
    check("clr pri false_cnt", int'(s_false_cnt), 0);
    check("clr pri popped", int'(s_out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
